// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - register map, status bits, opcodes and FSM states for calc_cmd_sequencer
package calc_pkg;

    localparam logic [2:0] REG_A      = 3'd0;
    localparam logic [2:0] REG_B      = 3'd1;
    localparam logic [2:0] REG_OP     = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_RES_LO = 3'd4;
    localparam logic [2:0] REG_RES_HI = 3'd5;

    localparam int ST_BUSY     = 0;
    localparam int ST_RES_VLD  = 1;
    localparam int ST_ERR      = 2;
    localparam int ST_TIMEOUT  = 3;
    localparam int ST_OVERRUN  = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6
    } calc_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } seq_state_e;

    function automatic logic [7:0] status_byte(input logic busy, input logic res_vld,
                                               input logic err, input logic timeout,
                                               input logic overrun);
        logic [7:0] s;
        s = 8'h00;
        s[ST_BUSY]    = busy;
        s[ST_RES_VLD] = res_vld;
        s[ST_ERR]     = err;
        s[ST_TIMEOUT] = timeout;
        s[ST_OVERRUN] = overrun;
        return s;
    endfunction

endpackage

// File: rtl/calc_timeout_ctr.sv
// rtl/calc_timeout_ctr.sv - cycle counter that flags expiry on the limit-th enabled cycle
module calc_timeout_ctr (
    input  logic       clk,      // system clock
    input  logic       rst_n,    // asynchronous active-low reset
    input  logic       clear,    // zero the count
    input  logic       enable,   // count this cycle
    input  logic [7:0] limit,    // number of enabled cycles allowed, 1..255
    output logic       expired   // high in the last allowed enabled cycle
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count starts at 0 in the first enabled cycle, so the limit-th cycle sees limit-1.
    assign expired = enable && (count_q == (limit - 8'd1));

endmodule

// File: rtl/calc_cmd_sequencer.sv
// rtl/calc_cmd_sequencer.sv - I2C register front end that sequences one calculator operation at a time
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int AUTO_INC       = 1
) (
    input  logic        clk,          // system clock
    input  logic        rst_n,        // asynchronous active-low reset
    input  logic        wr_valid,     // I2C byte written
    input  logic [7:0]  wr_data,      // written byte
    input  logic        wr_first,     // byte is the register pointer
    input  logic        rd_req,       // I2C needs next read byte
    output logic [7:0]  rd_data,      // read byte
    output logic        rd_valid,     // rd_data valid, one cycle after rd_req
    output logic [7:0]  op_a,         // operand A
    output logic [7:0]  op_b,         // operand B
    output logic [3:0]  op_code,      // operation select
    output logic        calc_start,   // one-cycle start pulse
    input  logic        calc_done,    // one-cycle completion pulse
    input  logic        calc_err,     // error, qualified by calc_done
    input  logic [15:0] calc_result   // result, qualified by calc_done
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    seq_state_e  state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic        res_vld_q, res_vld_d;
    logic        err_q, err_d;
    logic        timeout_q, timeout_d;
    logic        overrun_q, overrun_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    logic        ctr_clear, ctr_en, ctr_expired;
    logic        busy, op_wr;
    logic [2:0]  ptr_w;

    assign busy      = (state_q != S_IDLE);
    assign ctr_clear = (state_q == S_START);
    assign ctr_en    = (state_q == S_WAIT);

    calc_timeout_ctr u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .limit   (TO_LIMIT),
        .expired (ctr_expired)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_vld_d  = res_vld_q;
        err_d      = err_q;
        timeout_d  = timeout_q;
        overrun_d  = overrun_q;
        result_d   = result_q;
        shadow_d   = shadow_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        op_wr      = 1'b0;
        ptr_w      = ptr_q;
        ptr_d      = ptr_q;

        // Write side first: a same-cycle read sees the post-write pointer and contents.
        if (wr_valid) begin
            if (wr_first) begin
                ptr_w = wr_data[2:0];
            end else begin
                case (ptr_q)
                    REG_A: begin
                        if (busy) overrun_d = 1'b1;
                        else      a_d = wr_data;
                    end
                    REG_B: begin
                        if (busy) overrun_d = 1'b1;
                        else      b_d = wr_data;
                    end
                    REG_OP: begin
                        if (busy) begin
                            overrun_d = 1'b1;
                        end else begin
                            op_d  = wr_data[3:0];
                            op_wr = 1'b1;
                        end
                    end
                    REG_STATUS: begin
                        err_d     = 1'b0;
                        timeout_d = 1'b0;
                        overrun_d = 1'b0;
                    end
                    default: ;
                endcase
                if (AUTO_INC != 0) ptr_w = ptr_q + 3'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (op_wr) begin
                    state_d   = S_START;
                    res_vld_d = 1'b0;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion landing in the final allowed cycle still counts as done.
                if (calc_done) begin
                    state_d   = S_IDLE;
                    result_d  = calc_result;
                    err_d     = err_d | calc_err;
                    res_vld_d = 1'b1;
                end else if (ctr_expired) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Read data reflects register contents as they will be in the cycle it is presented.
        ptr_d = ptr_w;
        if (rd_req) begin
            rd_valid_d = 1'b1;
            case (ptr_w)
                REG_A:      rd_data_d = a_d;
                REG_B:      rd_data_d = b_d;
                REG_OP:     rd_data_d = {4'h0, op_d};
                REG_STATUS: rd_data_d = status_byte(state_d != S_IDLE, res_vld_d,
                                                    err_d, timeout_d, overrun_d);
                REG_RES_LO: begin
                    rd_data_d = result_d[7:0];
                    shadow_d  = result_d[15:8];
                end
                REG_RES_HI: rd_data_d = shadow_q;
                default:    rd_data_d = 8'h00;
            endcase
            if (AUTO_INC != 0) ptr_d = ptr_w + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= 3'd0;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            op_q       <= OP_ADD;
            res_vld_q  <= 1'b0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            result_q   <= 16'h0000;
            shadow_q   <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_vld_q  <= res_vld_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            result_q   <= result_d;
            shadow_q   <= shadow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Decoded from the state register so reset removes the pulse without waiting for a clock.
    assign calc_start = (state_q == S_START);
    assign op_a       = a_q;
    assign op_b       = b_q;
    assign op_code    = op_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb/tb_calc_cmd_sequencer.sv - self-checking bench for calc_cmd_sequencer
module tb_calc_cmd_sequencer;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_first = 1'b0;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [3:0]  op_code;
    logic        calc_start;
    logic        calc_done = 1'b0;
    logic        calc_err = 1'b0;
    logic [15:0] calc_result = 16'h0000;

    int ntests = 0;
    int nfail  = 0;

    calc_cmd_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .AUTO_INC(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_first    (wr_first),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_code     (op_code),
        .calc_start  (calc_start),
        .calc_done   (calc_done),
        .calc_err    (calc_err),
        .calc_result (calc_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a calculation is described by the cycle index of its start pulse;
    // the WAIT window is the TIMEOUT cycles that follow it.
    typedef struct {
        int unsigned cyc;
        int unsigned start_cyc;
        logic        busy;
        logic [2:0]  ptr;
        logic [7:0]  a, b;
        logic [3:0]  op;
        logic        rv, err, to, ov;
        logic [15:0] res;
        logic [7:0]  sh;
        logic [7:0]  rd;
        logic        rdv;
    } mstate_t;

    mstate_t m;

    always @(posedge clk or negedge rst_n) begin : model
        mstate_t n;
        logic    start_now;
        if (!rst_n) begin
            n = '{default: '0};
            m <= n;
        end else begin
            n = m;
            start_now = 1'b0;
            if (wr_valid) begin
                if (wr_first) begin
                    n.ptr = wr_data[2:0];
                end else begin
                    if (n.ptr <= 3'd2 && m.busy) n.ov = 1'b1;
                    else if (n.ptr == 3'd0) n.a = wr_data;
                    else if (n.ptr == 3'd1) n.b = wr_data;
                    else if (n.ptr == 3'd2) begin n.op = wr_data[3:0]; start_now = 1'b1; end
                    else if (n.ptr == 3'd3) begin n.err = 0; n.to = 0; n.ov = 0; end
                    n.ptr = n.ptr + 3'd1;
                end
            end
            if (m.busy && m.cyc > m.start_cyc) begin
                if (calc_done) begin
                    n.busy = 1'b0; n.res = calc_result; n.err = n.err | calc_err; n.rv = 1'b1;
                end else if (m.cyc - m.start_cyc == TIMEOUT) begin
                    n.busy = 1'b0; n.to = 1'b1;
                end
            end
            if (start_now) begin
                n.busy = 1'b1; n.start_cyc = m.cyc + 1; n.rv = 1'b0;
            end
            n.rdv = rd_req;
            if (rd_req) begin
                case (n.ptr)
                    3'd0: n.rd = n.a;
                    3'd1: n.rd = n.b;
                    3'd2: n.rd = {4'h0, n.op};
                    3'd3: n.rd = {3'b000, n.ov, n.to, n.err, n.rv, n.busy};
                    3'd4: begin n.rd = n.res[7:0]; n.sh = n.res[15:8]; end
                    3'd5: n.rd = m.sh;
                    default: n.rd = 8'h00;
                endcase
                n.ptr = n.ptr + 3'd1;
            end
            n.cyc = m.cyc + 1;
            m <= n;
        end
    end

    always @(negedge clk) begin
        chk("op_a", op_a, m.a);
        chk("op_b", op_b, m.b);
        chk("op_code", op_code, m.op);
        chk("calc_start", calc_start, m.busy && (m.cyc == m.start_cyc));
        chk("rd_valid", rd_valid, m.rdv);
        if (m.rdv) chk("rd_data", rd_data, m.rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_ptr(input logic [7:0] p);
        wr_valid = 1; wr_first = 1; wr_data = p;
        tick();
        wr_valid = 0; wr_first = 0;
    endtask

    task automatic wr_byte(input logic [7:0] d);
        wr_valid = 1; wr_first = 0; wr_data = d;
        tick();
        wr_valid = 0;
    endtask

    task automatic rd(output logic [7:0] d);
        rd_req = 1;
        tick();
        rd_req = 0;
        d = rd_data;
    endtask

    task automatic read_reg(input logic [7:0] p, output logic [7:0] d);
        wr_valid = 1; wr_first = 1; wr_data = p; rd_req = 1;
        tick();
        wr_valid = 0; wr_first = 0; rd_req = 0;
        d = rd_data;
    endtask

    task automatic pulse_done(input logic [15:0] r, input logic e);
        calc_done = 1; calc_result = r; calc_err = e;
        tick();
        calc_done = 0; calc_err = 0;
    endtask

    task automatic run_op(input logic [15:0] r);
        wr_ptr(8'd2);
        wr_byte(8'd0);
        tick();
        pulse_done(r, 1'b0);
    endtask

    initial begin : stim
        logic [7:0] d;
        int starts;

        repeat (3) tick();
        chk("reset op_a", op_a, 0);
        chk("reset calc_start", calc_start, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_data", rd_data, 0);
        rst_n = 1;
        tick();
        read_reg(8'd3, d);
        chk("reset status", d, 8'h00);

        // MUL 7*5
        wr_ptr(8'd0);
        wr_byte(8'h07);
        wr_byte(8'h05);
        wr_byte(8'h02);
        chk("mul start pulse", calc_start, 1);
        tick();
        chk("mul start one cycle", calc_start, 0);
        tick();
        tick();
        pulse_done(16'h0023, 1'b0);
        read_reg(8'd3, d); chk("mul status", d, 8'h02);
        rd(d);             chk("mul res_lo", d, 8'h23);
        rd(d);             chk("mul res_hi", d, 8'h00);

        // divide by zero
        wr_ptr(8'd0);
        wr_byte(8'h10);
        wr_byte(8'h00);
        wr_byte(8'h03);
        tick();
        pulse_done(16'h00FF, 1'b1);
        read_reg(8'd3, d); chk("div err status", d, 8'h06);
        wr_ptr(8'd3);
        wr_byte(8'hFF);
        read_reg(8'd3, d); chk("status after clear", d, 8'h02);

        // timeout: OP write in cycle n, busy still set in n+9, clear in n+10
        wr_ptr(8'd2);
        wr_byte(8'h01);
        repeat (7) tick();
        read_reg(8'd3, d); chk("timeout still busy", d, 8'h01);
        read_reg(8'd3, d); chk("timeout status", d, 8'h08);
        read_reg(8'd4, d); chk("timeout old result", d, 8'hFF);

        // overrun during WAIT
        wr_ptr(8'd3);
        wr_byte(8'h00);
        wr_ptr(8'd2);
        wr_byte(8'h04);
        wr_ptr(8'd0);
        wr_byte(8'h55);
        read_reg(8'd3, d); chk("overrun busy status", d, 8'h11);
        chk("op_a held", op_a, 8'h10);
        pulse_done(16'h0005, 1'b0);

        // OP write in the same cycle as done
        wr_ptr(8'd3);
        wr_byte(8'h00);
        wr_ptr(8'd2);
        wr_byte(8'h05);
        wr_ptr(8'd2);
        calc_done = 1; calc_result = 16'h0042;
        wr_valid = 1; wr_first = 0; wr_data = 8'h06;
        tick();
        calc_done = 0; wr_valid = 0;
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            if (calc_start) starts++;
            tick();
        end
        chk("no restart on race", starts, 0);
        chk("race op_code held", op_code, 4'h5);
        read_reg(8'd3, d); chk("race status", d, 8'h12);

        // result coherency across a LO/HI pair
        run_op(16'h1234);
        read_reg(8'd4, d); chk("coherent lo", d, 8'h34);
        run_op(16'hABCD);
        read_reg(8'd5, d); chk("coherent hi", d, 8'h12);
        read_reg(8'd4, d); chk("new lo", d, 8'hCD);
        rd(d);             chk("new hi", d, 8'hAB);

        // pointer wrap 7 -> 0
        wr_ptr(8'd7);
        wr_byte(8'h99);
        wr_byte(8'h3C);
        chk("wrap lands in A", op_a, 8'h3C);

        // reset while calc_start is high
        wr_ptr(8'd2);
        wr_byte(8'h01);
        chk("pre-reset start", calc_start, 1);
        #2 rst_n = 0;
        #1;
        chk("async calc_start", calc_start, 0);
        chk("async op_a", op_a, 0);
        chk("async op_b", op_b, 0);
        chk("async op_code", op_code, 0);
        chk("async rd_data", rd_data, 0);
        chk("async rd_valid", rd_valid, 0);
        tick();
        rst_n = 1;
        tick();
        pulse_done(16'hBEEF, 1'b1);
        read_reg(8'd3, d); chk("late done ignored", d, 8'h00);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            wr_valid    = ($urandom_range(0, 2) == 0);
            wr_first    = ($urandom_range(0, 3) == 0);
            wr_data     = 8'($urandom);
            rd_req      = ($urandom_range(0, 2) == 0);
            calc_done   = ($urandom_range(0, 5) == 0);
            calc_err    = ($urandom_range(0, 3) == 0);
            calc_result = 16'($urandom);
            tick();
        end
        wr_valid = 0; wr_first = 0; rd_req = 0; calc_done = 0; calc_err = 0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
